rv32i_mem_arbiter: RTL and testbench

//  Shares one single-port memory between the RV32I core's instruction-fetch port (port I)
//  and load/store port (port D). Fixed priority to D, plus a starvation guard for I.

---
 rtl/rv32i_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Shares one single-port memory between the instruction-fetch port (I) and the
// load/store port (D). D has fixed priority, and a starvation counter forces
// one I grant after STARVE_LIMIT consecutive D grants made while I was waiting.
// One transaction is in flight at a time. A transaction that waits TIMEOUT
// cycles without mem_ack is aborted with an error.
module rv32i_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_LIMIT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic              sel_i;   // 1 = the transaction in flight belongs to port I
  logic [SCNT_W-1:0] scnt;
  logic [WCNT_W-1:0] wcnt;

  // I wins only when D is absent or D has starved a waiting I for long enough.
  logic pick_i;
  assign pick_i = i_req && (!d_req || (scnt == SCNT_MAX));

  // Last permitted wait cycle; a mem_ack in this same cycle still wins.
  logic timeout_hit;
  assign timeout_hit = TIMEOUT_EN && (wcnt == WCNT_LAST);

  // Arbitration FSM with all bus and completion outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_i     <= 1'b0;
      scnt      <= '0;
      wcnt      <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      busy      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            wcnt    <= '0;
            sel_i   <= pick_i;
            if (pick_i) begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              scnt      <= '0;
            end else begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_we ? d_wstrb : 4'b0000;
              if (!i_req) begin
                scnt <= '0;
              end else if (scnt != SCNT_MAX) begin
                scnt <= scnt + SCNT_W'(1);
              end
            end
          end
        end
        ACCESS: begin
          if (mem_ack || timeout_hit) begin
            state   <= DONE;
            mem_req <= 1'b0;
            rdata   <= mem_ack ? mem_rdata : 32'h0;
            if (sel_i) begin
              i_ack <= 1'b1;
              i_err <= !mem_ack;
            end else begin
              d_ack <= 1'b1;
              d_err <= !mem_ack;
            end
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter
// Scenario tasks drive the two request ports, a behavioural memory answers
// mem_req after a programmable delay, and a scoreboard queue holds the
// completion each request should produce.
module tb_rv32i_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic        d_err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        is_i;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // memory model controls
  bit          rsp_en    = 1'b1;
  int          rsp_delay = -1;
  int          rsp_cnt   = 0;
  logic [31:0] rsp_data  = 32'h0;

  rv32i_mem_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ack(i_ack),
    .i_err(i_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_wstrb(d_wstrb),
    .d_ack(d_ack),
    .d_err(d_err),
    .rdata(rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: acks rsp_delay cycles after the first mem_req cycle (negative = never).
  always @(negedge clock) begin
    if (rsp_en) begin
      if (mem_req && !mem_ack) begin
        if (rsp_delay >= 0 && rsp_cnt == rsp_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rsp_data;
        end else begin
          rsp_cnt   = rsp_cnt + 1;
          mem_rdata = 32'h0BAD_0000 | rsp_cnt;
        end
      end else begin
        mem_ack   = 1'b0;
        rsp_cnt   = 0;
        mem_rdata = 32'h0BAD_FFFF;
      end
    end
  end

  // Scoreboard: every completion pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && (i_ack || d_ack)) begin
      total++;
      if (i_ack && d_ack) begin
        bad++;
        $display("FAIL ack_both: i_ack=%0b d_ack=%0b, required only one", i_ack, d_ack);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b rdata=%h, required no ack", i_ack, d_ack, rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({i_ack, (i_ack ? i_err : d_err), rdata} !== {mon_e.is_i, mon_e.err, mon_e.data}) begin
          bad++;
          $display("FAIL completion: port_i=%0b err=%0b rdata=%h, required port_i=%0b err=%0b rdata=%h",
                   i_ack, (i_ack ? i_err : d_err), rdata, mon_e.is_i, mon_e.err, mon_e.data);
        end
      end
    end
  end

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!(i_ack || d_ack) && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, i_ack, i_err, d_ack, d_err, rdata, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: mem_req=%0b busy=%0b mem_addr=%h rdata=%h, required all zero",
               mem_req, busy, mem_addr, rdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({busy, mem_req} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%0b mem_req=%0b, required 0 0", busy, mem_req);
    end
  endtask

  task automatic test_fetch();
    int n;
    rsp_delay = 2;
    rsp_data  = 32'hDEADBEEF;
    i_addr    = 32'h100;
    i_req     = 1'b1;
    exp_q.push_back('{is_i: 1'b1, err: 1'b0, data: 32'hDEADBEEF});
    @(negedge clock);
    total++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'h0, 32'h100, 32'h0}) begin
      bad++;
      $display("FAIL fetch_cmd: req=%0b we=%0b wstrb=%h addr=%h wdata=%h, required 1 0 0 00000100 00000000",
               mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    wait_done(50, n);
    i_req = 1'b0;
    total++;
    if (n !== 3 || i_ack !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL fetch_latency: cycles=%0d i_ack=%0b busy=%0b, required 3 1 1", n, i_ack, busy);
    end
    @(negedge clock);
    total++;
    if ({i_ack, busy, rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL fetch_after: i_ack=%0b busy=%0b rdata=%h, required 0 0 deadbeef", i_ack, busy, rdata);
    end
  endtask

  task automatic test_arbitration();
    bit got[5];
    int acks;
    int n;
    for (int r = 0; r < 2; r++) begin
      rsp_delay = 0;
      rsp_data  = 32'h1111_0000 + r;
      d_we      = 1'b1;
      d_addr    = 32'h200;
      d_wdata   = 32'hA0A0_0000 + r;
      d_wstrb   = 4'hF;
      i_addr    = 32'h180;
      i_req     = 1'b1;
      d_req     = 1'b1;
      for (int k = 0; k < 5; k++)
        exp_q.push_back('{is_i: (k == 4), err: 1'b0, data: 32'h1111_0000 + r});
      acks = 0;
      n = 0;
      while (acks < 5 && n < 300) begin
        @(negedge clock);
        n++;
        if (i_ack || d_ack) begin
          got[acks] = i_ack;
          acks++;
          if (i_ack) begin
            i_req = 1'b0;
            d_req = 1'b0;
          end
        end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      total++;
      if (acks !== 5 || {got[0], got[1], got[2], got[3], got[4]} !== 5'b00001) begin
        bad++;
        $display("FAIL grant_order round=%0d: acks=%0d order(1=I)=%b, required 5 00001",
                 r, acks, {got[0], got[1], got[2], got[3], got[4]});
      end
      wait_idle();
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int hi;
    int n;
    rsp_delay = -1;
    d_we      = 1'b0;
    d_addr    = 32'h300;
    d_req     = 1'b1;
    exp_q.push_back('{is_i: 1'b0, err: 1'b1, data: 32'h0});
    hi = 0;
    n  = 0;
    while (!(i_ack || d_ack) && n < 100) begin
      @(negedge clock);
      n++;
      if (mem_req) hi++;
    end
    d_req = 1'b0;
    total++;
    if (hi !== 16 || d_ack !== 1'b1 || d_err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout: mem_req_cycles=%0d d_ack=%0b d_err=%0b busy=%0b, required 16 1 1 1",
               hi, d_ack, d_err, busy);
    end
    @(negedge clock);
    total++;
    if ({busy, d_ack, d_err, mem_req} !== 4'b0000) begin
      bad++;
      $display("FAIL timeout_after: busy=%0b d_ack=%0b d_err=%0b mem_req=%0b, required 0 0 0 0",
               busy, d_ack, d_err, mem_req);
    end
  endtask

  task automatic test_reset_mid_access();
    int n;
    rsp_delay = -1;
    d_we      = 1'b0;
    d_addr    = 32'h340;
    d_req     = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({mem_req, busy, i_ack, d_ack, rdata} !== '0) begin
      bad++;
      $display("FAIL async_reset: mem_req=%0b busy=%0b i_ack=%0b d_ack=%0b rdata=%h, required all zero",
               mem_req, busy, i_ack, d_ack, rdata);
    end
    d_req = 1'b0;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    rsp_delay = 1;
    rsp_data  = 32'hCAFEF00D;
    i_addr    = 32'h500;
    i_req     = 1'b1;
    exp_q.push_back('{is_i: 1'b1, err: 1'b0, data: 32'hCAFEF00D});
    @(negedge clock);
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
      bad++;
      $display("FAIL post_reset_grant: mem_req=%0b mem_addr=%h, required 1 00000500", mem_req, mem_addr);
    end
    wait_done(50, n);
    i_req = 1'b0;
    total++;
    if (n !== 2 || i_ack !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_fetch: cycles=%0d i_ack=%0b, required 2 1", n, i_ack);
    end
    wait_idle();
  endtask

  task automatic test_store();
    int hi;
    int cmd_bad;
    int n;
    rsp_delay = 3;
    rsp_data  = 32'h55AA55AA;
    d_we      = 1'b1;
    d_addr    = 32'h400;
    d_wdata   = 32'h12345678;
    d_wstrb   = 4'h3;
    d_req     = 1'b1;
    exp_q.push_back('{is_i: 1'b0, err: 1'b0, data: 32'h55AA55AA});
    hi = 0;
    cmd_bad = 0;
    n = 0;
    while (!(i_ack || d_ack) && n < 100) begin
      @(negedge clock);
      n++;
      if (mem_req) begin
        hi++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h400, 32'h12345678, 4'h3})
          cmd_bad++;
      end
    end
    d_req = 1'b0;
    total++;
    if (hi !== 4 || cmd_bad !== 0 || d_ack !== 1'b1) begin
      bad++;
      $display("FAIL store_cmd: mem_req_cycles=%0d bad_cmd_cycles=%0d d_ack=%0b, required 4 0 1",
               hi, cmd_bad, d_ack);
    end
    @(negedge clock);
    total++;
    if ({d_ack, i_ack} !== 2'b00) begin
      bad++;
      $display("FAIL store_single_pulse: d_ack=%0b i_ack=%0b, required 0 0", d_ack, i_ack);
    end
    wait_idle();
  endtask

  task automatic test_stray_ack();
    rsp_en = 1'b0;
    @(negedge clock);
    mem_rdata = 32'hBAD0BAD0;
    mem_ack   = 1'b1;
    @(negedge clock);
    mem_ack   = 1'b0;
    @(negedge clock);
    total++;
    if ({busy, mem_req, i_ack, d_ack} !== 4'b0000 || rdata !== 32'h55AA55AA) begin
      bad++;
      $display("FAIL stray_ack: busy=%0b mem_req=%0b i_ack=%0b d_ack=%0b rdata=%h, required 0 0 0 0 55aa55aa",
               busy, mem_req, i_ack, d_ack, rdata);
    end
    rsp_en = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset     = 1'b1;
    i_req     = 1'b0;
    i_addr    = 32'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    d_wstrb   = 4'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    test_reset();
    test_fetch();
    test_arbitration();
    test_timeout();
    test_reset_mid_access();
    test_store();
    test_stray_ack();

    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
